uart_receiver: RTL

Serial-to-byte receive path for the UART. It oversamples an asynchronous 8N1 line (idle high, LSB first), validates the start and stop bits, and pushes good bytes into an internal FIFO. Consumers drain the FIFO through a show-ahead valid/ack handshake. It is the receive counterpart of the existing transmit path and shares its baud setting and clock.

---
 rtl/uart_receiver.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   Oversampling 8N1 receiver (idle high, LSB first) with an internal
//   show-ahead receive FIFO.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   rx_pin      in   serial line, asynchronous to clk
//   rx_byte     out  byte at FIFO head (meaningful only while rx_valid=1)
//   rx_valid    out  FIFO non-empty
//   rx_ack      in   pop FIFO head at this edge (ignored when empty)
//   rx_level    out  FIFO occupancy, 0..FIFO_DEPTH
//   rx_overrun  out  sticky: a good byte was dropped because the FIFO was full
//   rx_clr_err  in   clears rx_overrun (a simultaneous drop wins)
//   frame_err   out  one-cycle pulse when a stop bit is sampled low
// ----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_pin,
    output logic [7:0]        rx_byte,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic [ADDR_W:0]   rx_level,
    output logic              rx_overrun,
    input  logic              rx_clr_err,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int LVL_W = ADDR_W + 1;

    // Start bit is checked half a period in; every later sample is one full
    // period after the previous one, so all bits are sampled mid-bit.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Synchronizer
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rxs_s;

    // Receive FSM
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              push_req_s;

    // FIFO
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              full_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;

    // Two-stage synchronizer inputs; reset value matches an idle line.
    always_comb begin
        sync1_d = rx_pin;
        sync2_d = sync1_q;
        rxs_s   = sync2_q;
    end

    // Receive state machine next-state and datapath.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_s) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    if (!rxs_s) begin
                        cnt_d   = '0;
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d[idx_q] = rxs_s;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxs_s) begin
                        push_req_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Hold here until the line recovers so a long break yields
                // a single frame error.
                if (rxs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FIFO push/pop arbitration, pointer/level update and overrun flag.
    always_comb begin
        full_s    = (level_q == LVL_FULL);
        pop_s     = rx_ack && (level_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok_s = push_req_s && (!full_s || pop_s);
        drop_s    = push_req_s && full_s && !pop_s;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (rx_clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            mem_q       <= '{default: 8'h00};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
        end
    end

    // Output mapping; rx_byte is show-ahead from the head entry.
    always_comb begin
        rx_byte    = mem_q[rd_ptr_q];
        rx_valid   = (level_q != '0);
        rx_level   = level_q;
        rx_overrun = overrun_q;
        frame_err  = frame_err_q;
    end

endmodule
